// File: rtl/spi_device_pkg.sv
// Shared types and constants for the byte-oriented SPI device endpoint.
package spi_device_pkg;

  typedef enum logic {
    Idle  = 1'b0,
    Shift = 1'b1
  } state_e;

  localparam logic [7:0] FillByteDefault = 8'hFF;
  localparam int RxFifoDepth = 4;
  localparam int RxPtrW = $clog2(RxFifoDepth);
  localparam logic [RxPtrW:0] RxFifoFull = (RxPtrW + 1)'(RxFifoDepth);

endpackage

// File: rtl/spi_device_sync.sv
// Multi-bit synchroniser for the SPI pins plus a rise/fall detector on the
// synchronised sck. SyncStages must be at least 2.
module spi_device_sync #(
  parameter int               Width        = 2,
  parameter int               SyncStages   = 2,
  parameter logic [Width-1:0] DataResetVal = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             sck_i,
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] data_o,
  output logic             sck_rise_o,
  output logic             sck_fall_o
);

  logic [Width-1:0] data_q [SyncStages];
  logic             sck_q  [SyncStages];
  logic             sck_prev_q;

  // Synchroniser chains; sck resets to its idle-high level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < SyncStages; i++) begin
        data_q[i] <= DataResetVal;
        sck_q[i]  <= 1'b1;
      end
      sck_prev_q <= 1'b1;
    end else begin
      data_q[0] <= data_i;
      sck_q[0]  <= sck_i;
      for (int i = 1; i < SyncStages; i++) begin
        data_q[i] <= data_q[i-1];
        sck_q[i]  <= sck_q[i-1];
      end
      sck_prev_q <= sck_q[SyncStages-1];
    end
  end

  assign data_o     = data_q[SyncStages-1];
  assign sck_rise_o = sck_q[SyncStages-1] & ~sck_prev_q;
  assign sck_fall_o = ~sck_q[SyncStages-1] & sck_prev_q;

endmodule

// File: rtl/spi_device_byte.sv
// SPI mode-3 device endpoint, MSB first, with valid/ready byte handshakes.
// Define SPI_DEVICE_RX_FIFO_EN to replace the rx holding register by a 4-entry FIFO.
module spi_device_byte
  import spi_device_pkg::*;
#(
  parameter int         SyncStages = 2,
  parameter logic [7:0] FillByte   = FillByteDefault
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       sck_i,
  input  logic       csb_i,
  input  logic       mosi_i,
  output logic       miso_o,
  output logic       miso_en_o,
  input  logic [7:0] tx_byte_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic [7:0] rx_byte_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       rx_overflow_o,
  output logic       tx_underrun_o,
  output logic       active_o
);

  logic [1:0] sync_data_s;
  logic       csb_s, mosi_s, sck_rise_s, sck_fall_s, csb_fall_s, csb_rise_s;

  // csb synchroniser resets low so a csb held low through reset is not
  // mistaken for a fresh falling edge.
  spi_device_sync #(
    .Width       (2),
    .SyncStages  (SyncStages),
    .DataResetVal(2'b10)
  ) u_sync (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .sck_i     (sck_i),
    .data_i    ({mosi_i, csb_i}),
    .data_o    (sync_data_s),
    .sck_rise_o(sck_rise_s),
    .sck_fall_o(sck_fall_s)
  );

  assign csb_s  = sync_data_s[0];
  assign mosi_s = sync_data_s[1];

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [6:0] rx_sh_q, rx_sh_d;
  logic [7:0] tx_sh_q, tx_sh_d, tx_load_s;
  logic [7:0] tx_hold_q, tx_hold_d;
  logic       tx_ready_q, tx_ready_d;
  logic       csb_prev_q, miso_q, miso_d, miso_en_q, active_q, active_d;
  logic       underrun_q, underrun_d, overflow_q, overflow_d;
  logic       consume_s, byte_done_s;
  logic [7:0] rx_new_s;

  assign csb_fall_s = csb_prev_q & ~csb_s;
  assign csb_rise_s = ~csb_prev_q & csb_s;
  assign rx_new_s   = {rx_sh_q, mosi_s};

  // Protocol FSM, bit counter and shift registers.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rx_sh_d     = rx_sh_q;
    tx_sh_d     = tx_sh_q;
    tx_load_s   = FillByte;
    miso_d      = miso_q;
    consume_s   = 1'b0;
    underrun_d  = 1'b0;
    byte_done_s = 1'b0;
    case (state_q)
      Idle: begin
        miso_d = 1'b1;
        cnt_d  = 3'd0;
        if (csb_fall_s) begin
          state_d = Shift;
        end else begin
          state_d = Idle;
        end
      end
      Shift: begin
        if (csb_rise_s) begin
          state_d = Idle;
          cnt_d   = 3'd0;
          miso_d  = 1'b1;
        end else if (sck_fall_s) begin
          if (cnt_q == 3'd0) begin
            if (!tx_ready_q) begin
              tx_load_s = tx_hold_q;
              consume_s = 1'b1;
            end else begin
              tx_load_s  = FillByte;
              underrun_d = 1'b1;
            end
            tx_sh_d = tx_load_s;
            miso_d  = tx_load_s[7];
          end else begin
            miso_d = tx_sh_q[3'd7 - cnt_q];
          end
        end else if (sck_rise_s) begin
          rx_sh_d     = {rx_sh_q[5:0], mosi_s};
          cnt_d       = cnt_q + 3'd1;
          byte_done_s = (cnt_q == 3'd7);
        end else begin
          state_d = Shift;
        end
      end
      default: begin
        state_d = Idle;
        cnt_d   = 3'd0;
        miso_d  = 1'b1;
      end
    endcase
    active_d = (state_d == Shift);
  end

  // tx holding register; a consume always frees it, so a new byte waits a cycle.
  always_comb begin
    tx_hold_d  = tx_hold_q;
    tx_ready_d = tx_ready_q;
    if (consume_s) begin
      tx_ready_d = 1'b1;
    end else if (tx_valid_i && tx_ready_q) begin
      tx_hold_d  = tx_byte_i;
      tx_ready_d = 1'b0;
    end else begin
      tx_ready_d = tx_ready_q;
    end
  end

  // Core state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= Idle;
      cnt_q      <= 3'd0;
      rx_sh_q    <= 7'd0;
      tx_sh_q    <= 8'd0;
      tx_hold_q  <= 8'd0;
      tx_ready_q <= 1'b1;
      csb_prev_q <= 1'b0;
      miso_q     <= 1'b1;
      miso_en_q  <= 1'b0;
      active_q   <= 1'b0;
      underrun_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rx_sh_q    <= rx_sh_d;
      tx_sh_q    <= tx_sh_d;
      tx_hold_q  <= tx_hold_d;
      tx_ready_q <= tx_ready_d;
      csb_prev_q <= csb_s;
      miso_q     <= miso_d;
      miso_en_q  <= active_d;
      active_q   <= active_d;
      underrun_q <= underrun_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef SPI_DEVICE_RX_FIFO_EN
  logic [7:0]        fifo_q [RxFifoDepth];
  logic [RxPtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [RxPtrW:0]   count_q, count_d;
  logic              pop_s, push_s, full_s;

  // rx FIFO control; a full FIFO still accepts a byte when popped that cycle.
  always_comb begin
    full_s     = (count_q == RxFifoFull);
    pop_s      = (count_q != {(RxPtrW + 1){1'b0}}) && rx_ready_i;
    push_s     = byte_done_s && (!full_s || pop_s);
    overflow_d = byte_done_s && full_s && !pop_s;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + (RxPtrW + 1)'(1);
      2'b01:   count_d = count_q - (RxPtrW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // rx FIFO storage and pointers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < RxFifoDepth; i++) begin
        fifo_q[i] <= 8'd0;
      end
      wr_ptr_q <= {RxPtrW{1'b0}};
      rd_ptr_q <= {RxPtrW{1'b0}};
      count_q  <= {(RxPtrW + 1){1'b0}};
    end else begin
      if (push_s) begin
        fifo_q[wr_ptr_q] <= rx_new_s;
        wr_ptr_q         <= wr_ptr_q + RxPtrW'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + RxPtrW'(1);
      end
      count_q <= count_d;
    end
  end

  assign rx_byte_o  = fifo_q[rd_ptr_q];
  assign rx_valid_o = (count_q != {(RxPtrW + 1){1'b0}});
`else
  logic [7:0] rx_byte_q, rx_byte_d;
  logic       rx_valid_q, rx_valid_d, rx_accept_s;

  // rx holding register; completion on the accept cycle replaces the byte.
  always_comb begin
    rx_byte_d   = rx_byte_q;
    rx_valid_d  = rx_valid_q;
    overflow_d  = 1'b0;
    rx_accept_s = rx_valid_q && rx_ready_i;
    if (byte_done_s) begin
      if (!rx_valid_q || rx_accept_s) begin
        rx_byte_d  = rx_new_s;
        rx_valid_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end else if (rx_accept_s) begin
      rx_valid_d = 1'b0;
    end else begin
      rx_valid_d = rx_valid_q;
    end
  end

  // rx holding registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_byte_q  <= 8'd0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_byte_q  <= rx_byte_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign rx_byte_o  = rx_byte_q;
  assign rx_valid_o = rx_valid_q;
`endif

  assign miso_o        = miso_q;
  assign miso_en_o     = miso_en_q;
  assign tx_ready_o    = tx_ready_q;
  assign rx_overflow_o = overflow_q;
  assign tx_underrun_o = underrun_q;
  assign active_o      = active_q;

endmodule

// File: tb/tb_spi_device_byte.sv
// Directed and randomised-backpressure bench for spi_device_byte.
module tb_spi_device_byte;

  logic       clk = 1'b0;
  logic       rst_ni, sck, csb, mosi, miso_o, miso_en_o;
  logic [7:0] tx_byte;
  logic       tx_valid, tx_ready_o;
  logic [7:0] rx_byte_o;
  logic       rx_valid_o, rx_ready, rx_overflow_o, tx_underrun_o, active_o;

  int vectors = 0;
  int miscompares = 0;
  int ovf_cnt = 0, und_cnt = 0, rxv_rise = 0;
  logic rxv_prev = 1'b0;
  logic host_done = 1'b0;

  always #5 clk = ~clk;

  spi_device_byte dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .sck_i        (sck),
    .csb_i        (csb),
    .mosi_i       (mosi),
    .miso_o       (miso_o),
    .miso_en_o    (miso_en_o),
    .tx_byte_i    (tx_byte),
    .tx_valid_i   (tx_valid),
    .tx_ready_o   (tx_ready_o),
    .rx_byte_o    (rx_byte_o),
    .rx_valid_o   (rx_valid_o),
    .rx_ready_i   (rx_ready),
    .rx_overflow_o(rx_overflow_o),
    .tx_underrun_o(tx_underrun_o),
    .active_o     (active_o)
  );

  // Pulse and rising-edge counters sampled mid-cycle.
  always @(negedge clk) begin
    if (rx_overflow_o === 1'b1) ovf_cnt <= ovf_cnt + 1;
    if (tx_underrun_o === 1'b1) und_cnt <= und_cnt + 1;
    if (rx_valid_o === 1'b1 && rxv_prev === 1'b0) rxv_rise <= rxv_rise + 1;
    rxv_prev <= rx_valid_o;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Host side of mode 3: drive on falling sck, read miso at the end of the high phase.
  task automatic spi_bits(input logic [7:0] mo, input int nbits, input int half,
                          output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      sck  = 1'b0;
      mosi = mo[7-i];
      wait_clk(half);
      sck = 1'b1;
      wait_clk(half);
      mi[7-i] = miso_o;
    end
  endtask

  task automatic load_tx(input logic [7:0] b);
    tx_byte  = b;
    tx_valid = 1'b1;
    wait_clk(1);
    tx_valid = 1'b0;
  endtask

  task automatic pop_rx();
    rx_ready = 1'b1;
    wait_clk(1);
    rx_ready = 1'b0;
  endtask

  logic [7:0] mi, mi2;
  logic [7:0] txq[$], hostq[$], sentq[$], gotq[$], nonff[$];
  int ovf0, und0, rxv0, ffs;

  initial begin
    rst_ni = 1'b0; sck = 1'b1; csb = 1'b1; mosi = 1'b1;
    tx_byte = 8'h00; tx_valid = 1'b0; rx_ready = 1'b0;
    wait_clk(3);
    check("rst_miso", 32'(miso_o), 32'h1);
    check("rst_miso_en", 32'(miso_en_o), 32'h0);
    check("rst_tx_ready", 32'(tx_ready_o), 32'h1);
    check("rst_rx_byte", 32'(rx_byte_o), 32'h0);
    check("rst_rx_valid", 32'(rx_valid_o), 32'h0);
    check("rst_overflow", 32'(rx_overflow_o), 32'h0);
    check("rst_underrun", 32'(tx_underrun_o), 32'h0);
    check("rst_active", 32'(active_o), 32'h0);
    rst_ni = 1'b1;
    wait_clk(6);

    // Basic exchange: host sends A5, reads preloaded 3C.
    ovf0 = ovf_cnt; und0 = und_cnt; rxv0 = rxv_rise;
    load_tx(8'h3C);
    check("t1_tx_ready_low", 32'(tx_ready_o), 32'h0);
    csb = 1'b0;
    wait_clk(4);
    check("t1_active", 32'(active_o), 32'h1);
    check("t1_miso_en", 32'(miso_en_o), 32'h1);
    spi_bits(8'hA5, 8, 4, mi);
    wait_clk(6);
    check("t1_host_rd", 32'(mi), 32'h3C);
    check("t1_rx_byte", 32'(rx_byte_o), 32'hA5);
    check("t1_rx_valid", 32'(rx_valid_o), 32'h1);
    check("t1_rxv_rises", 32'(rxv_rise - rxv0), 32'h1);
    check("t1_tx_ready_back", 32'(tx_ready_o), 32'h1);
    check("t1_no_underrun", 32'(und_cnt - und0), 32'h0);
    pop_rx();
    wait_clk(1);
    check("t1_rx_cleared", 32'(rx_valid_o), 32'h0);
    csb = 1'b1;
    wait_clk(8);
    check("t1_miso_en_off", 32'(miso_en_o), 32'h0);
    check("t1_miso_idle", 32'(miso_o), 32'h1);

    // Two bytes, nothing loaded: FillByte twice with two underrun pulses.
    ovf0 = ovf_cnt; und0 = und_cnt; rxv0 = rxv_rise;
    rx_ready = 1'b1;
    csb = 1'b0;
    wait_clk(4);
    spi_bits(8'h01, 8, 4, mi);
    spi_bits(8'h80, 8, 4, mi2);
    wait_clk(4);
    csb = 1'b1;
    wait_clk(8);
    rx_ready = 1'b0;
    check("t2_host_rd0", 32'(mi), 32'hFF);
    check("t2_host_rd1", 32'(mi2), 32'hFF);
    check("t2_underruns", 32'(und_cnt - und0), 32'h2);
    check("t2_rxv_rises", 32'(rxv_rise - rxv0), 32'h2);
    check("t2_no_overflow", 32'(ovf_cnt - ovf0), 32'h0);
`ifndef SPI_DEVICE_RX_FIFO_EN
    check("t2_last_byte", 32'(rx_byte_o), 32'h80);
`endif
    check("t2_rx_empty", 32'(rx_valid_o), 32'h0);

    // Backpressure: consumer never ready.
    ovf0 = ovf_cnt;
    csb = 1'b0;
    wait_clk(4);
    spi_bits(8'h11, 8, 4, mi);
    spi_bits(8'h22, 8, 4, mi);
`ifdef SPI_DEVICE_RX_FIFO_EN
    spi_bits(8'h33, 8, 4, mi);
    spi_bits(8'h44, 8, 4, mi);
    wait_clk(6);
    check("t3_fifo_no_ovf", 32'(ovf_cnt - ovf0), 32'h0);
    spi_bits(8'h55, 8, 4, mi);
`endif
    wait_clk(6);
    csb = 1'b1;
    wait_clk(8);
    check("t3_overflow", 32'(ovf_cnt - ovf0), 32'h1);
    check("t3_rx_byte", 32'(rx_byte_o), 32'h11);
    check("t3_rx_valid", 32'(rx_valid_o), 32'h1);
`ifdef SPI_DEVICE_RX_FIFO_EN
    pop_rx();
    check("t3_fifo_1", 32'(rx_byte_o), 32'h22);
    pop_rx();
    check("t3_fifo_2", 32'(rx_byte_o), 32'h33);
    pop_rx();
    check("t3_fifo_3", 32'(rx_byte_o), 32'h44);
`endif
    pop_rx();
    wait_clk(1);
    check("t3_drained", 32'(rx_valid_o), 32'h0);

    // csb raised after 5 bits, then a clean C3 byte.
    rxv0 = rxv_rise;
    load_tx(8'h96);
    csb = 1'b0;
    wait_clk(4);
    spi_bits(8'hFF, 5, 4, mi);
    wait_clk(4);
    csb = 1'b1;
    wait_clk(8);
    check("t4_no_rx", 32'(rxv_rise - rxv0), 32'h0);
    check("t4_rx_valid", 32'(rx_valid_o), 32'h0);
    check("t4_miso_en", 32'(miso_en_o), 32'h0);
    check("t4_miso", 32'(miso_o), 32'h1);
    check("t4_tx_consumed", 32'(tx_ready_o), 32'h1);
    check("t4_partial_rd", 32'(mi), 32'h90);
    load_tx(8'h5E);
    csb = 1'b0;
    wait_clk(4);
    spi_bits(8'hC3, 8, 4, mi);
    wait_clk(4);
    csb = 1'b1;
    wait_clk(8);
    check("t4_rx_byte", 32'(rx_byte_o), 32'hC3);
    check("t4_rx_valid2", 32'(rx_valid_o), 32'h1);
    check("t4_host_rd", 32'(mi), 32'h5E);
    pop_rx();

    // Reset at bit 3; no transfer until a fresh csb falling edge.
    load_tx(8'h42);
    csb = 1'b0;
    wait_clk(4);
    spi_bits(8'hAA, 3, 4, mi);
    rst_ni = 1'b0;
    #1;
    check("t5_miso", 32'(miso_o), 32'h1);
    check("t5_miso_en", 32'(miso_en_o), 32'h0);
    check("t5_tx_ready", 32'(tx_ready_o), 32'h1);
    check("t5_rx_valid", 32'(rx_valid_o), 32'h0);
    check("t5_rx_byte", 32'(rx_byte_o), 32'h0);
    check("t5_active", 32'(active_o), 32'h0);
    wait_clk(3);
    rst_ni = 1'b1;
    wait_clk(4);
    spi_bits(8'h77, 8, 4, mi);
    wait_clk(8);
    check("t5_stale_rx", 32'(rx_valid_o), 32'h0);
    check("t5_stale_active", 32'(active_o), 32'h0);
    csb = 1'b1;
    wait_clk(8);
    csb = 1'b0;
    wait_clk(4);
    spi_bits(8'h5A, 8, 4, mi);
    wait_clk(4);
    csb = 1'b1;
    wait_clk(8);
    check("t5_rx_byte2", 32'(rx_byte_o), 32'h5A);
    check("t5_rx_valid2", 32'(rx_valid_o), 32'h1);
    pop_rx();
    wait_clk(4);

    // sck at clk/4 with random producer and consumer backpressure.
    ovf0 = ovf_cnt; und0 = und_cnt;
    fork
      begin
        csb = 1'b0;
        wait_clk(4);
        for (int k = 0; k < 20; k++) begin
          logic [7:0] b;
          b = 8'($urandom_range(0, 255));
          sentq.push_back(b);
          spi_bits(b, 8, 2, mi);
          hostq.push_back(mi);
        end
        wait_clk(8);
        csb = 1'b1;
        wait_clk(20);
        host_done = 1'b1;
      end
      begin
        for (int k = 0; k < 60 && !host_done; k++) begin
          int tmo;
          wait_clk($urandom_range(0, 12));
          tx_byte  = 8'($urandom_range(0, 254));
          tx_valid = 1'b1;
          tmo = 0;
          while (tx_ready_o !== 1'b1 && !host_done && tmo < 5000) begin
            @(negedge clk);
            tmo++;
          end
          if (tx_ready_o === 1'b1) txq.push_back(tx_byte);
          @(negedge clk);
          tx_valid = 1'b0;
        end
      end
      begin
        for (int c = 0; c < 20000; c++) begin
          @(negedge clk);
          if (host_done && rx_valid_o !== 1'b1) break;
          rx_ready = 1'($urandom_range(0, 1));
          if (rx_valid_o === 1'b1 && rx_ready) gotq.push_back(rx_byte_o);
        end
        rx_ready = 1'b0;
      end
    join
    wait_clk(4);
    check("t6_host_count", 32'(hostq.size()), 32'd20);
    check("t6_rx_count", 32'(gotq.size()), 32'd20);
    for (int i = 0; i < 20 && i < gotq.size(); i++) begin
      check($sformatf("t6_rx_%0d", i), 32'(gotq[i]), 32'(sentq[i]));
    end
    ffs = 0;
    foreach (hostq[i]) begin
      if (hostq[i] == 8'hFF) ffs++;
      else nonff.push_back(hostq[i]);
    end
    check("t6_underruns", 32'(und_cnt - und0), 32'(ffs));
    check("t6_no_overflow", 32'(ovf_cnt - ovf0), 32'h0);
    for (int i = 0; i < nonff.size() && i < txq.size(); i++) begin
      check($sformatf("t6_tx_%0d", i), 32'(nonff[i]), 32'(txq[i]));
    end
    check("t6_tx_pending", 32'(txq.size() - nonff.size()), (tx_ready_o === 1'b1) ? 32'h0 : 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
